demorgan_input_debounce: RTL and testbench

Two-channel input conditioner that sits directly upstream of the De Morgan NOR-form gate stage (`e = ~a & ~b`). It takes raw, asynchronous switch/button levels `a_raw` and `b_raw`, synchronizes each into the `clk` domain, debounces each independently, and drives clean, glitch-free `a` and `b` levels into the gate. It also emits a one-cycle `upd` pulse whenever either conditioned output changes, plus a `busy` status.

---
 rtl/demorgan_input_debounce.sv | 120 ++++++++++++
 tb/tb_demorgan_input_debounce.sv | 116 +++++++++++
 2 files changed

// File: rtl/demorgan_input_debounce.sv
// Two-channel synchronizer + debouncer feeding the De Morgan NOR-form gate (e = ~a & ~b).
// Each channel is an independent lane: 2-FF sync, STABLE/CHECK FSM with a saturating-free window counter.

module demorgan_input_debounce_ch #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic chg,
  output logic chk
);
  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sync;
  logic            s2;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            out_nxt;

  assign s2 = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= STABLE;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
    end
  end

  // Any sample matching out while checking restarts the window from scratch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    chg       = 1'b0;
    case (state)
      STABLE: begin
        if (s2 != out) begin
          state_nxt = CHECK;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHECK: begin
        if (s2 == out) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(N-1)) begin
          out_nxt   = s2;
          state_nxt = STABLE;
          cnt_nxt   = '0;
          chg       = 1'b1;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign chk = (state_nxt == CHECK);
endmodule

module demorgan_input_debounce #(
  parameter int N  = 1000000,
  parameter int CW = $clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic upd,
  output logic busy
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] raw, out, chg, chk;

  assign raw = {b_raw, a_raw};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demorgan_input_debounce_ch #(.N(N), .CW(CW)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .out   (out[i]),
      .chg   (chg[i]),
      .chk   (chk[i])
    );
  end

  // Both taken from next-state terms so they line up with the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd  <= 1'b0;
      busy <= 1'b0;
    end else begin
      upd  <= |chg;
      busy <= |chk;
    end
  end

  assign a = out[0];
  assign b = out[1];
endmodule

// File: tb/tb_demorgan_input_debounce.sv
// Directed bench for demorgan_input_debounce at N=4: reset, clean edge, glitch, bounce, simultaneous, mid-window reset.

module tb_demorgan_input_debounce;
  logic clk = 1'b0, rst_n = 1'b0, a_raw = 1'b0, b_raw = 1'b0;
  logic a, b, upd, busy;
  int   n_chk = 0, n_fail = 0;

  demorgan_input_debounce #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw),
    .a(a), .b(b), .upd(upd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has just changed inputs; the next edge is k0. Outputs assumed 0 beforehand.
  task automatic watch_rise(input string tag, input bit ea, input bit eb);
    int ups = 0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      chk({tag, ".a"},    a,    (ea && e >= 5) ? 1 : 0);
      chk({tag, ".b"},    b,    (eb && e >= 5) ? 1 : 0);
      chk({tag, ".upd"},  upd,  (e == 5) ? 1 : 0);
      chk({tag, ".busy"}, busy, (e >= 2 && e <= 4) ? 1 : 0);
      if (upd) ups++;
    end
    chk({tag, ".npulse"}, ups, 1);
  endtask

  task automatic settle(input string tag, input bit ea, input bit eb);
    repeat (10) tick();
    chk({tag, ".a"},    a,    ea);
    chk({tag, ".b"},    b,    eb);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".upd"},  upd,  0);
  endtask

  initial begin
    int ups;
    int bsy;
    // Reset with both raw inputs high
    a_raw = 1'b1; b_raw = 1'b1;
    repeat (3) tick();
    chk("rst.a", a, 0); chk("rst.b", b, 0);
    chk("rst.upd", upd, 0); chk("rst.busy", busy, 0);
    rst_n = 1'b1;
    watch_rise("rel", 1, 1);

    a_raw = 1'b0; b_raw = 1'b0;
    settle("fall", 0, 0);

    a_raw = 1'b1;
    watch_rise("clean", 1, 0);
    a_raw = 1'b0;
    settle("clean_back", 0, 0);

    // Glitch: three sampling edges of high, then low
    a_raw = 1'b1;
    ups = 0; bsy = 0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 2) a_raw = 1'b0;
      chk("glitch.a", a, 0);
      if (upd) ups++;
      if (busy) bsy++;
    end
    chk("glitch.upd", ups, 0);
    chk("glitch.busyseen", (bsy > 0) ? 1 : 0, 1);
    chk("glitch.busyend", busy, 0);

    // Bounce: high 2 edges, low 1 edge, then held high from k1
    a_raw = 1'b1;
    tick(); tick();
    a_raw = 1'b0;
    tick();
    a_raw = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      chk("bounce.a", a, (e >= 5) ? 1 : 0);
    end
    a_raw = 1'b0;
    settle("bounce_back", 0, 0);

    a_raw = 1'b1; b_raw = 1'b1;
    watch_rise("simul", 1, 1);
    a_raw = 1'b0; b_raw = 1'b0;
    settle("simul_back", 0, 0);

    // Reset in the middle of a b window
    b_raw = 1'b1;
    tick(); tick(); tick(); tick();
    chk("midrst.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.b", b, 0); chk("midrst.busy", busy, 0);
    chk("midrst.upd", upd, 0); chk("midrst.a", a, 0);
    tick(); tick();
    rst_n = 1'b1;
    watch_rise("midrst_rel", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
